muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit and its sequencing controller for the RV32M extension of the pipelined core. It sits in the EX stage beside the ALU and accepts an operation when the decoded instruction is an M-extension R-type (OP=0110011, funct7=0000001). It runs a shift-add multiply or a restoring divide over XLEN cycles. It stalls the pipeline while busy and presents a one-cycle-valid result for writeback.

Parameters:
XLEN, 32, operand and result width
FAST_SPECIAL, 1, when 1, divide-by-zero and signed-overflow cases complete without iterating

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  EX stage holds a valid M-extension instruction
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_i  input  XLEN  operand A (dividend / multiplicand)
rs2_i  input  XLEN  operand B (divisor / multiplier)
flush_i  input  1  pipeline flush; aborts any operation in flight
stall_o  output  1  freeze IF/ID/EX; combinational
busy_o  output  1  state is not IDLE
valid_o  output  1  result_o valid this cycle (single-cycle pulse)
result_o  output  XLEN  operation result

Behaviour:
- Reset: state=IDLE; valid_o=0, busy_o=0, stall_o=0, result_o=0; all internal registers cleared. Reset mid-operation aborts immediately and produces no valid_o.
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC on start_i=1 && flush_i=0:
  - latch op, sign flags, absolute operands (signed ops only; for MULHSU only rs1 is treated as signed);
  - clear the 2*XLEN accumulator and set the iteration counter to 0.
- IDLE → DONE on the same condition when FAST_SPECIAL=1 and the operation is a special case:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1;
  - signed overflow (DIV with rs1 = 0x80000000 and rs2 = all ones): quotient = 0x80000000, REM = 0.
- CALC: one multiply or divide step per cycle.
  - Multiply: conditional add of the multiplicand, then shift right.
  - Divide: shift left, trial subtract, set the quotient bit.
  - Counter increments each cycle; after XLEN cycles (counter = XLEN-1 at the edge) → FIX.
  - When FAST_SPECIAL=0, special cases iterate normally; results must still equal the values above.
- FIX (1 cycle):
  - negate the product when the operand signs differ;
  - negate the quotient when the signs differ; the remainder takes the sign of the dividend;
  - select the low word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder into result_o.
  - → DONE.
- DONE (1 cycle): valid_o=1, result_o held, → IDLE. result_o keeps its value until the next DONE.
- Latency:
  - normal: valid_o is high exactly XLEN+2 cycles after the edge that sampled start_i (34 for XLEN=32);
  - special fast path: 1 cycle.
- stall_o = (state==IDLE && start_i && !flush_i) || state==CALC || state==FIX. It is low in DONE so the pipeline advances and captures result_o in that cycle.
- busy_o = (state != IDLE).
- start_i while busy is ignored; the pipeline is frozen, so it is the same instruction.
- flush_i in any non-IDLE state → IDLE next edge; valid_o is not asserted for the aborted operation. flush_i in DONE suppresses valid_o that cycle.
- A start_i in the first IDLE cycle after DONE is accepted (back-to-back M instructions).
- Arithmetic: internal accumulator is 2*XLEN+1 bits; absolute value of 0x80000000 is handled as unsigned 2^31 without overflow.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) → stall_o high for 33 cycles, valid_o at cycle 34, result_o=0xFFFFFFEB.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIVU rs1=5, rs2=0 → valid_o 1 cycle after start, result 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush at cycle 10 of a DIV → busy_o=0 next cycle, no valid_o; a following MUL 3×4 returns 12 after 34 cycles.
- Back-to-back: DIVU 100/7 then start_i in the cycle after DONE with REMU 100/7 → results 14 then 2, with no idle gap beyond DONE.
- rst_n asserted at cycle 20 of a MULH → outputs 0 immediately (asynchronously), state IDLE, no valid_o after release.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its EX-stage sequencing FSM.
// Multiply is shift-add and divide is restoring, one bit per cycle. Operands
// are converted to magnitudes on entry and the signs are fixed up in FIX.
module muldiv_sequencer #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched operation context
    logic [2:0]      op_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic            div_zero_q;
    logic [XLEN-1:0] opa_q;       // multiplicand / dividend shift register
    logic [XLEN-1:0] opb_q;       // multiplier shift register / divisor
    logic [2*XLEN:0] acc_q;       // product, or {remainder, quotient}
    logic [CW-1:0]   cnt_q;

    // Entry decode
    logic            sign_a_in, sign_b_in;
    logic [XLEN-1:0] abs_a_in, abs_b_in;
    logic            div_zero_in, ovf_in, fast_take;
    logic [XLEN-1:0] fast_result;
    logic            accept;

    // Step datapath
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] mul_acc_next;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] div_diff;
    logic            div_ge;
    logic [2*XLEN:0] div_acc_next;

    // Sign fix-up and result select
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_result;

    assign accept = (state_q == S_IDLE) && start_i && !flush_i;

    // Decode operand signedness, magnitudes and the special divide cases
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        sign_a_in   = 1'b0;
        sign_b_in   = 1'b0;
        case (op_i)
            OP_MULH, OP_DIV, OP_REM: begin
                sign_a_in = rs1_i[XLEN-1];
                sign_b_in = rs2_i[XLEN-1];
            end
            OP_MULHSU: sign_a_in = rs1_i[XLEN-1];
            default: ;
        endcase
        abs_a_in    = sign_a_in ? ('0 - rs1_i) : rs1_i;
        abs_b_in    = sign_b_in ? ('0 - rs2_i) : rs2_i;

        div_zero_in = op_i[2] && (rs2_i == '0);
        ovf_in      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (rs1_i == INT_MIN) && (rs2_i == '1);
        fast_take   = (FAST_SPECIAL != 0) && (div_zero_in || ovf_in);

        // op_i[1] distinguishes REM/REMU from DIV/DIVU
        fast_result = '0;
        if (div_zero_in)
            fast_result = op_i[1] ? rs1_i : '1;
        else if (ovf_in)
            fast_result = op_i[1] ? '0 : INT_MIN;
    end

    // One multiply step (add-then-shift) and one restoring divide step
    always_comb begin
        mul_sum      = acc_q[2*XLEN:XLEN] + (opb_q[0] ? {1'b0, opa_q} : '0);
        mul_acc_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};

        rem_sh       = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
        div_diff     = {1'b0, rem_sh} - {2'b00, opb_q};
        div_ge       = ~div_diff[XLEN+1];
        div_acc_next = {(div_ge ? div_diff[XLEN:0] : rem_sh), acc_q[XLEN-2:0], div_ge};
    end

    // Restore signs and pick the requested word
    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? ('0 - acc_q[2*XLEN-1:0]) : acc_q[2*XLEN-1:0];
        // Divide by zero keeps the all-ones quotient regardless of dividend sign
        quot_s = ((a_neg_q ^ b_neg_q) && !div_zero_q) ? ('0 - acc_q[XLEN-1:0])
                                                      : acc_q[XLEN-1:0];
        rem_s  = a_neg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                       fix_result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quot_s;
            default:                      fix_result = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and pipeline handshake outputs
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        busy_o  = (state_q != S_IDLE);
        valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = fast_take ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                if (flush_i)
                    state_d = S_IDLE;
                else if (cnt_q == CW'(XLEN-1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                stall_o = 1'b1;
                state_d = flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                valid_o = !flush_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register is reset so an aborted operation leaves no stale state visible.
        if (!rst_n) begin
            op_q       <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_o   <= '0;
        end else if (accept) begin
            op_q       <= op_i;
            a_neg_q    <= sign_a_in;
            b_neg_q    <= sign_b_in;
            div_zero_q <= div_zero_in;
            opa_q      <= abs_a_in;
            opb_q      <= abs_b_in;
            acc_q      <= '0;
            cnt_q      <= '0;
            if (fast_take)
                result_o <= fast_result;
        end else if (state_q == S_CALC && !flush_i) begin
            cnt_q <= cnt_q + CW'(1);
            if (op_q[2]) begin
                acc_q <= div_acc_next;
                opa_q <= opa_q << 1;
            end else begin
                acc_q <= mul_acc_next;
                opb_q <= opb_q >> 1;
            end
        end else if (state_q == S_FIX && !flush_i) begin
            result_o <= fix_result;
        end
    end

endmodule
